vape_exec_tracker: RTL
======================

VAPE_EXEC_TRACKER -- requirements
Module: vape_exec_tracker

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the run-cycle counter.
REQ-002 SHALL have a single clock `clk` and a synchronous, active-low reset `reset_n`; no other clock or reset exists.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 reset_n  input  1  synchronous active-low reset.
REQ-005 pc  input  16  current program counter.
REQ-006 ER_min  input  16  executable region first instruction address.
REQ-007 ER_max  input  16  executable region last instruction address.
REQ-008 exec  input  1  combined monitor verdict (1 = no violation this cycle).
REQ-009 exec1..exec5  input  1 each  per-property verdicts: immutability, atomicity/irq, reset, output protection, boundary.
REQ-010 exec_flag  output  1  registered proof-of-execution flag.
REQ-011 state  output  2  FSM state: 0 IDLE, 1 RUN, 2 DONE, 3 FAIL.
REQ-012 cause  output  6  sticky failure cause: bit k-1 = execk low (k=1..5); bit5 = premature ER exit.
REQ-013 run_cycles  output  CNT_W  cycles spent in the current/last ER run.
REQ-014 done_pulse  output  1  one-cycle pulse on entry to DONE.
REQ-015 fail_pulse  output  1  one-cycle pulse on entry to FAIL.

Function
REQ-016 All outputs SHALL be registered; every transition SHALL be taken on the clock edge following the cycle in which its condition is sampled.
REQ-017 "entry" SHALL mean exec==1 & pc==ER_min & ER_min<=ER_max; when ER_min>ER_max, entry SHALL never occur.
REQ-018 IDLE: on entry, go to RUN, set run_cycles=1, cause=0, exec_flag=0; if additionally ER_min==ER_max, go directly to DONE, set exec_flag=1, and pulse done_pulse.
REQ-019 RUN, priority order: (a) exec==0 -> FAIL, cause[4:0] = inverted {exec5..exec1} sampled that cycle, cause[5]=0; (b) pc outside [ER_min,ER_max] -> FAIL, cause=6'b100000; (c) pc==ER_max -> DONE, exec_flag=1; (d) otherwise remain in RUN.
REQ-020 In RUN, run_cycles SHALL increment by 1 per cycle, including the exiting cycle, and SHALL saturate at all-ones without wrapping.
REQ-021 DONE: exec_flag SHALL hold 1 while exec==1; exec==0 -> FAIL with cause captured as in REQ-019a; entry -> RUN with exec_flag=0, run_cycles=1, cause=0.
REQ-022 FAIL: exec_flag=0; cause and run_cycles hold; entry -> RUN as in REQ-018; no other exit except reset.
REQ-023 exec_flag SHALL be 1 only in DONE.
REQ-024 done_pulse and fail_pulse SHALL each be high exactly one cycle per entry into DONE/FAIL and never simultaneously.
REQ-025 exec==0 and pc==ER_max in the same RUN cycle SHALL resolve to FAIL.
REQ-026 run_cycles SHALL hold its value in IDLE, DONE and FAIL.
REQ-027 ER_min/ER_max changing mid-run SHALL be compared live each cycle; no latching.

Reset
REQ-028 reset_n==0 at a rising edge SHALL force state=IDLE, exec_flag=0, cause=0, run_cycles=0, done_pulse=0, fail_pulse=0, overriding every other condition, including mid-RUN.
REQ-029 The first transition after reset release SHALL be evaluated on the first edge with reset_n==1.

Verification
REQ-030 ER=[E000,E010], exec=1, pc steps E000..E010 by 2 -> state RUN for 8 cycles then DONE; exec_flag=1; run_cycles=9; done_pulse for one cycle.
REQ-031 Same run, exec=0 and exec4=0 at pc=E006 -> FAIL; cause=6'b001000; exec_flag=0; run_cycles=4; fail_pulse for one cycle.
REQ-032 RUN, pc jumps to C000 with exec=1 -> FAIL; cause=6'b100000; later entry at E000 -> RUN; cause=0; run_cycles=1.
REQ-033 DONE, then exec drops with exec1=0 -> FAIL; exec_flag falls next cycle; cause=6'b000001.
REQ-034 reset_n=0 during RUN at run_cycles=5 -> next edge: IDLE; all outputs 0; ER_min=F000 with ER_max=E000 at pc=F000 -> remains IDLE.
REQ-035 ER_min=ER_max=E000, pc=E000, exec=1 from IDLE -> DONE next cycle; run_cycles=1; exec_flag=1.

Source files
------------

// File: rtl/vape_exec_tracker.sv
// vape_exec_tracker: tracks one execution of the executable region (ER) and produces a
// registered proof-of-execution flag.
//
// A run starts when the monitor is clean and the PC sits on ER_min. It completes when the PC
// reaches ER_max without leaving the region and without a monitor violation. Any violation
// moves the tracker to FAIL and records a sticky cause. Region bounds are compared live every
// cycle.
//
// Ports:
//   clk          system clock, rising edge
//   reset_n      synchronous active-low reset
//   pc           current program counter
//   ER_min       first instruction address of the executable region
//   ER_max       last instruction address of the executable region
//   exec         combined monitor verdict (1 = clean this cycle)
//   exec1..exec5 per-property verdicts (immutability, atomicity/irq, reset, output, boundary)
//   exec_flag    registered proof-of-execution flag, high only in DONE
//   state        0 IDLE, 1 RUN, 2 DONE, 3 FAIL
//   cause        sticky failure cause; bit k-1 = execk low, bit 5 = premature ER exit
//   run_cycles   cycles spent in the current/last run, saturating
//   done_pulse   one-cycle pulse on entry to DONE
//   fail_pulse   one-cycle pulse on entry to FAIL
module vape_exec_tracker #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [15:0]      pc,
  input  logic [15:0]      ER_min,
  input  logic [15:0]      ER_max,
  input  logic             exec,
  input  logic             exec1,
  input  logic             exec2,
  input  logic             exec3,
  input  logic             exec4,
  input  logic             exec5,
  output logic             exec_flag,
  output logic [1:0]       state,
  output logic [5:0]       cause,
  output logic [CNT_W-1:0] run_cycles,
  output logic             done_pulse,
  output logic             fail_pulse
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2,
    StFail = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic               flag_q, flag_d;
  logic [5:0]         cause_q, cause_d;
  logic [CNT_W-1:0]   rc_q, rc_d;
  logic               done_q, done_d;
  logic               fail_q, fail_d;

  logic               entry;
  logic               in_er;
  logic               single_instr;
  logic [5:0]         verdict_cause;
  logic [CNT_W-1:0]   rc_inc;

  // An inverted region (ER_min > ER_max) can never be entered.
  assign entry         = exec & (pc == ER_min) & (ER_min <= ER_max);
  assign in_er         = (pc >= ER_min) & (pc <= ER_max);
  assign single_instr  = (ER_min == ER_max);
  assign verdict_cause = {1'b0, ~{exec5, exec4, exec3, exec2, exec1}};
  assign rc_inc        = (&rc_q) ? rc_q : rc_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    rc_d    = rc_q;
    done_d  = 1'b0;
    fail_d  = 1'b0;

    case (state_q)
      StIdle, StFail: begin
        if (entry) begin
          rc_d    = CNT_W'(1);
          cause_d = 6'd0;
          if (single_instr) begin
            state_d = StDone;
            done_d  = 1'b1;
          end else begin
            state_d = StRun;
          end
        end
      end

      StRun: begin
        // The exiting cycle is counted too.
        rc_d = rc_inc;
        if (!exec) begin
          state_d = StFail;
          cause_d = verdict_cause;
          fail_d  = 1'b1;
        end else if (!in_er) begin
          state_d = StFail;
          cause_d = 6'b100000;
          fail_d  = 1'b1;
        end else if (pc == ER_max) begin
          state_d = StDone;
          done_d  = 1'b1;
        end
      end

      StDone: begin
        if (!exec) begin
          state_d = StFail;
          cause_d = verdict_cause;
          fail_d  = 1'b1;
        end else if (entry) begin
          state_d = StRun;
          rc_d    = CNT_W'(1);
          cause_d = 6'd0;
        end
      end

      default: state_d = StIdle;
    endcase

    flag_d = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StIdle;
      flag_q  <= 1'b0;
      cause_q <= 6'd0;
      rc_q    <= '0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      flag_q  <= flag_d;
      cause_q <= cause_d;
      rc_q    <= rc_d;
      done_q  <= done_d;
      fail_q  <= fail_d;
    end
  end

  assign exec_flag  = flag_q;
  assign state      = state_q;
  assign cause      = cause_q;
  assign run_cycles = rc_q;
  assign done_pulse = done_q;
  assign fail_pulse = fail_q;

endmodule
